// File: rtl/sha1_msg_ctrl_pkg.sv
// sha1_msg_ctrl_pkg: shared SHA-1 types, initial chaining value and controller states
package sha1_msg_ctrl_pkg;
   typedef logic [31:0] word_t;
   typedef logic [15:0][31:0] block_t;
   // element 4 holds H0 so the flat 160-bit vector reads {H0,H1,H2,H3,H4}
   typedef logic [4:0][31:0] digest_t;
   localparam digest_t SHA1_IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   function automatic digest_t digest_add(digest_t h, digest_t r);
      digest_t s;
      for (int k = 0; k < 5; k++) s[k] = h[k] + r[k];
      return s;
   endfunction
endpackage

// File: rtl/sha1_msg_ctrl_if.sv
// sha1_msg_ctrl_if: block input, engine request/result and digest output streams
interface sha1_msg_ctrl_if #(parameter int CNT_W = 32);
   import sha1_msg_ctrl_pkg::*;
   logic i_tvalid, o_tready, i_first, i_last;
   block_t i_block;
   logic o_unit_tvalid, i_unit_tready, i_unit_tvalid, o_unit_tready;
   logic [79:0][31:0] o_unit_data;
   word_t o_unit_A, o_unit_B, o_unit_C, o_unit_D, o_unit_E;
   word_t i_unit_A, i_unit_B, i_unit_C, i_unit_D, i_unit_E;
   logic o_tvalid, i_tready, o_err;
   logic [159:0] o_digest;
   logic [CNT_W-1:0] o_blk_cnt;
   modport slave (
      input i_tvalid, i_first, i_last, i_block, i_unit_tready, i_unit_tvalid,
      input i_unit_A, i_unit_B, i_unit_C, i_unit_D, i_unit_E, i_tready,
      output o_tready, o_unit_tvalid, o_unit_tready, o_unit_data,
      output o_unit_A, o_unit_B, o_unit_C, o_unit_D, o_unit_E, o_tvalid, o_digest, o_blk_cnt, o_err
   );
   modport master (
      output i_tvalid, i_first, i_last, i_block, i_unit_tready, i_unit_tvalid,
      output i_unit_A, i_unit_B, i_unit_C, i_unit_D, i_unit_E, i_tready,
      input o_tready, o_unit_tvalid, o_unit_tready, o_unit_data,
      input o_unit_A, o_unit_B, o_unit_C, o_unit_D, o_unit_E, o_tvalid, o_digest, o_blk_cnt, o_err
   );
endinterface

// File: rtl/sha1_msg_ctrl.sv
// sha1_msg_ctrl: sequences padded blocks through the SHA-1 engine and emits message digests
module sha1_msg_ctrl
   import sha1_msg_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic reset_n,
   sha1_msg_ctrl_if.slave bus
);
   state_t state, nxt;
   block_t blk;
   digest_t h;
   logic last_q, msg_open, err;
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk)
      state <= !reset_n ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.i_tvalid ? ISSUE : IDLE;
         ISSUE:   nxt = bus.i_unit_tready ? WAIT : ISSUE;
         WAIT:    nxt = !bus.i_unit_tvalid ? WAIT : last_q ? DONE : IDLE;
         DONE:    nxt = bus.i_tready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      bus.o_tready = state == IDLE;
      bus.o_unit_tvalid = state == ISSUE;
      bus.o_unit_tready = state == WAIT;
      bus.o_tvalid = state == DONE;
      bus.o_unit_data = '0;
      bus.o_unit_data[15:0] = blk;
      {bus.o_unit_A, bus.o_unit_B, bus.o_unit_C, bus.o_unit_D, bus.o_unit_E} = h;
      bus.o_digest = h;
      bus.o_blk_cnt = cnt;
      bus.o_err = err;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blk <= '0;
         last_q <= 1'b0;
         msg_open <= 1'b0;
         h <= SHA1_IV;
         cnt <= '0;
         err <= 1'b0;
      end else begin
         err <= 1'b0;
         if (state == IDLE && bus.i_tvalid) begin
            blk <= bus.i_block;
            last_q <= bus.i_last;
            // a continuation block with no open message is hashed as a fresh first block
            if (bus.i_first || !msg_open) begin
               h <= SHA1_IV;
               cnt <= '0;
               msg_open <= 1'b1;
            end
            err <= !bus.i_first && !msg_open;
         end
         if (state == WAIT && bus.i_unit_tvalid) begin
            h <= digest_add(h, {bus.i_unit_A, bus.i_unit_B, bus.i_unit_C, bus.i_unit_D, bus.i_unit_E});
            cnt <= cnt + 1'b1;
            if (last_q) msg_open <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sha1_msg_ctrl.sv
// tb_sha1_msg_ctrl: directed vectors for sha1_msg_ctrl against a behavioural SHA-1 round engine
module tb_sha1_msg_ctrl;
   import sha1_msg_ctrl_pkg::*;
   localparam int ENG_LAT = 8;
   localparam logic [159:0] D_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [159:0] D_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
   typedef struct {
      block_t blk;
      logic first, last, chk;
      logic [159:0] dig;
      logic [31:0] cnt;
   } vec_t;
   logic clk = 1'b0;
   logic reset_n;
   int n_vec = 0, n_err = 0, err_seen = 0, tv_rise = 0;
   logic tv_prev = 1'b0;
   logic eng_busy;
   int eng_cnt;
   logic [159:0] eng_res;
   sha1_msg_ctrl_if #(.CNT_W(32)) bus();
   sha1_msg_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [159:0] sha1_compress(input logic [79:0][31:0] m, input logic [159:0] hin);
      logic [31:0] w[80];
      logic [31:0] a, b, c, d, e, f, k, t;
      {a, b, c, d, e} = hin;
      for (int i = 0; i < 80; i++) begin
         if (i < 16) w[i] = m[i];
         else begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
         end
         f = i < 20 ? (b & c) | (~b & d) : i < 40 ? b ^ c ^ d : i < 60 ? (b & c) | (b & d) | (c & d) : b ^ c ^ d;
         k = i < 20 ? 32'h5A827999 : i < 40 ? 32'h6ED9EBA1 : i < 60 ? 32'h8F1BBCDC : 32'hCA62C1D6;
         t = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d;
         d = c;
         c = {b[1:0], b[31:2]};
         b = a;
         a = t;
      end
      return {a, b, c, d, e};
   endfunction
   // round engine: raw compression result (no feed-forward) after ENG_LAT cycles
   assign bus.i_unit_tready = !eng_busy;
   always @(posedge clk) begin
      if (!reset_n) begin
         eng_busy <= 1'b0;
         eng_cnt <= 0;
         bus.i_unit_tvalid <= 1'b0;
      end else if (!eng_busy) begin
         if (bus.o_unit_tvalid) begin
            eng_busy <= 1'b1;
            eng_cnt <= ENG_LAT;
            eng_res <= sha1_compress(bus.o_unit_data, {bus.o_unit_A, bus.o_unit_B, bus.o_unit_C, bus.o_unit_D, bus.o_unit_E});
         end
      end else if (bus.i_unit_tvalid) begin
         if (bus.o_unit_tready) begin
            bus.i_unit_tvalid <= 1'b0;
            eng_busy <= 1'b0;
         end
      end else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
      else begin
         bus.i_unit_tvalid <= 1'b1;
         {bus.i_unit_A, bus.i_unit_B, bus.i_unit_C, bus.i_unit_D, bus.i_unit_E} <= eng_res;
      end
   end
   always @(negedge clk) begin
      if (bus.o_err) err_seen <= err_seen + 1;
      if (bus.o_tvalid && !tv_prev) tv_rise <= tv_rise + 1;
      tv_prev <= bus.o_tvalid;
   end
   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask
   task automatic wait_ready(input string name);
      int n = 0;
      while (!bus.o_tready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready_timeout"}, bus.o_tready, 1);
   endtask
   task automatic send(input block_t b, input logic f, input logic l);
      @(negedge clk);
      wait_ready("send");
      bus.i_block = b;
      bus.i_first = f;
      bus.i_last = l;
      bus.i_tvalid = 1'b1;
      @(negedge clk);
      bus.i_tvalid = 1'b0;
      check("in_flight_tready", bus.o_tready, 0);
   endtask
   task automatic wait_digest(input string name, input logic [159:0] dig, input logic [31:0] cnt);
      int n = 0;
      while (!bus.o_tvalid && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, "_tvalid"}, bus.o_tvalid, 1);
      check({name, "_digest"}, bus.o_digest, dig);
      check({name, "_blk_cnt"}, bus.o_blk_cnt, cnt);
      bus.i_tready = 1'b1;
      @(negedge clk);
      bus.i_tready = 1'b0;
   endtask
   initial begin
      vec_t tbl[4];
      block_t b_abc, b_empty, b_two1, b_two2;
      word_t two_w[14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                           32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                           32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
      int e0, t0;
      reset_n = 1'b0;
      bus.i_tvalid = 1'b0;
      bus.i_first = 1'b0;
      bus.i_last = 1'b0;
      bus.i_block = '0;
      bus.i_tready = 1'b0;
      b_abc = '0;
      b_abc[0] = 32'h61626380;
      b_abc[15] = 32'h00000018;
      b_empty = '0;
      b_empty[0] = 32'h80000000;
      b_two1 = '0;
      for (int i = 0; i < 14; i++) b_two1[i] = two_w[i];
      b_two1[14] = 32'h80000000;
      b_two2 = '0;
      b_two2[15] = 32'h000001c0;
      tbl[0] = '{b_abc, 1'b1, 1'b1, 1'b1, D_ABC, 32'd1};
      tbl[1] = '{b_empty, 1'b1, 1'b1, 1'b1, D_EMPTY, 32'd1};
      tbl[2] = '{b_two1, 1'b1, 1'b0, 1'b0, '0, 32'd1};
      tbl[3] = '{b_two2, 1'b0, 1'b1, 1'b1, D_TWO, 32'd2};
      do_reset();
      check("rst_tready", bus.o_tready, 1);
      check("rst_unit_tvalid", bus.o_unit_tvalid, 0);
      check("rst_unit_tready", bus.o_unit_tready, 0);
      check("rst_tvalid", bus.o_tvalid, 0);
      check("rst_err", bus.o_err, 0);
      check("rst_blk_cnt", bus.o_blk_cnt, 0);
      check("rst_chain", {bus.o_unit_A, bus.o_unit_B, bus.o_unit_C, bus.o_unit_D, bus.o_unit_E}, SHA1_IV);
      e0 = err_seen;
      for (int i = 0; i < 4; i++) begin
         send(tbl[i].blk, tbl[i].first, tbl[i].last);
         if (tbl[i].chk) wait_digest($sformatf("vec%0d", i), tbl[i].dig, tbl[i].cnt);
         else begin
            wait_ready($sformatf("vec%0d", i));
            check($sformatf("vec%0d_blk_cnt", i), bus.o_blk_cnt, tbl[i].cnt);
         end
      end
      check("table_no_err", err_seen - e0, 0);
      // digest held under backpressure while a new block waits
      send(b_abc, 1'b1, 1'b1);
      for (int n = 0; n < 500 && !bus.o_tvalid; n++) @(negedge clk);
      bus.i_block = b_empty;
      bus.i_first = 1'b1;
      bus.i_last = 1'b1;
      bus.i_tvalid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check("bp_tvalid", bus.o_tvalid, 1);
         check("bp_digest", bus.o_digest, D_ABC);
         check("bp_tready", bus.o_tready, 0);
      end
      bus.i_tready = 1'b1;
      @(negedge clk);
      bus.i_tready = 1'b0;
      check("bp_after_hs_tready", bus.o_tready, 1);
      @(negedge clk);
      bus.i_tvalid = 1'b0;
      check("bp_accept_tready", bus.o_tready, 0);
      wait_digest("bp_empty", D_EMPTY, 1);
      // abandoned message: only the restarted single-block digest appears
      e0 = err_seen;
      t0 = tv_rise;
      send(b_two1, 1'b1, 1'b0);
      wait_ready("abandon");
      send(b_abc, 1'b1, 1'b1);
      wait_digest("abandon", D_ABC, 1);
      check("abandon_no_err", err_seen - e0, 0);
      check("abandon_one_digest", tv_rise - t0, 1);
      // continuation block with no open message
      do_reset();
      e0 = err_seen;
      send(b_abc, 1'b0, 1'b1);
      wait_digest("orphan", D_ABC, 1);
      check("orphan_err_once", err_seen - e0, 1);
      // reset while waiting on the engine
      send(b_two1, 1'b1, 1'b0);
      for (int n = 0; n < 500 && !bus.o_unit_tready; n++) @(negedge clk);
      check("midrst_in_wait", bus.o_unit_tready, 1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("midrst_tready", bus.o_tready, 1);
      check("midrst_unit_tready", bus.o_unit_tready, 0);
      check("midrst_tvalid", bus.o_tvalid, 0);
      check("midrst_blk_cnt", bus.o_blk_cnt, 0);
      check("midrst_chain", {bus.o_unit_A, bus.o_unit_B, bus.o_unit_C, bus.o_unit_D, bus.o_unit_E}, SHA1_IV);
      send(b_abc, 1'b1, 1'b1);
      wait_digest("midrst_abc", D_ABC, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sha1_msg_ctrl.md
Name: sha1_msg_ctrl

Overview:
Message-level sequencer for the single-block SHA-1 round engine (sha1_unit).
- Accepts pre-padded 512-bit message blocks tagged first/last.
- Drives each block plus the current chaining value into the engine, then adds the engine result back into the chaining value (mod 2^32 per word).
- Emits the 160-bit digest after the last block of each message.

Parameters:
CNT_W, 32, width of the per-message block counter o_blk_cnt

Ports:
clk  in  1  clock
reset_n  in  1  reset; one clock; synchronous, active-low; sampled on the rising edge of clk
i_tvalid  in  1  block valid
o_tready  out  1  controller can accept a block
i_block  in  16x32  padded block, word 0 = first big-endian word
i_first  in  1  block starts a new message
i_last  in  1  block ends the message
o_unit_tvalid  out  1  request to engine
i_unit_tready  in  1  engine ready
o_unit_data  out  80x32  words 0..15 = latched block; words 16..79 driven 0
o_unit_A..o_unit_E  out  32 each  chaining value H0..H4 presented to engine
i_unit_tvalid  in  1  engine result valid
o_unit_tready  out  1  controller accepts engine result
i_unit_A..i_unit_E  in  32 each  engine result
o_tvalid  out  1  digest valid
i_tready  in  1  downstream accepts digest
o_digest  out  160  {H0,H1,H2,H3,H4}, H0 in [159:128]
o_blk_cnt  out  CNT_W  blocks absorbed in current message
o_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - FSM->IDLE; msg_open=0; H=IV; o_blk_cnt=0.
  - o_tready=1 after reset; o_unit_tvalid, o_unit_tready, o_tvalid and o_err all 0.
  - Reset mid-message discards all state; the engine shares the same reset.
- FSM states:
  - IDLE: o_tready=1. On i_tvalid, latch i_block and i_last -> ISSUE.
    - If i_first, or !msg_open: chaining H loads IV in the same edge; o_blk_cnt=0; msg_open=1.
    - If !i_first && !msg_open: additionally pulse o_err; the block is treated as first.
  - ISSUE: o_unit_tvalid=1; o_unit_A..E=H; data stable until i_unit_tready sampled high -> WAIT.
  - WAIT: o_unit_tready=1. On i_unit_tvalid: H[k] <= H[k] + i_unit_X (mod 2^32); o_blk_cnt++ (wraps at 2^CNT_W).
    - If latched last: -> DONE, msg_open=0.
    - Otherwise: -> IDLE.
  - DONE: o_tvalid=1, o_digest=H, held stable until i_tready; on handshake -> IDLE.
- o_tready=1 only in IDLE, so at most one block is in flight; no input buffering.
- Latency, last block accepted -> o_tvalid: 2 + engine cycles from engine accept to result (about 82 with the current engine).
- Simultaneous events:
  - i_first with a message open: abandons the open message (no digest), restarts from IV, no error.
  - i_first && i_last: single-block message.
- A stale i_unit_tvalid outside WAIT is ignored; o_unit_tready=0 there.
- IV: 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.

Decomposition:
- Shared package sha1_pkg:
  - word_t (32-bit), block_t (16 x word_t), digest_t (5 x word_t)
  - SHA1_IV constant array
  - FSM state enum (IDLE, ISSUE, WAIT, DONE)
- No sub-module. Wrapper sha1_core instantiates sha1_msg_ctrl + sha1_unit.

Test Plan:
- "abc": one block {61626380, 0 x14, 00000018}, first=last=1 -> o_digest = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d; o_blk_cnt=1.
- Empty message: {80000000, 0 x15}, first=last=1 -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first, then last) -> 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1; o_blk_cnt=2; o_tready low while each block is in flight.
- Backpressure: i_tready held 0 for 20 cycles after "abc" -> o_tvalid and o_digest stable; new i_tvalid is not accepted until the digest handshake.
- Protocol:
  - First block of the two-block message, then "abc" with first=1 -> only the "abc" digest appears, o_err stays 0.
  - A block with first=0 after reset -> o_err pulses once, hashed as first.
- Reset asserted during WAIT -> next cycle state matches reset values; a subsequent "abc" yields the correct digest.
